// File: rtl/exec_pkg.sv
// exec_pkg: shared definitions for the execute stage.
//   - AluControl operation codes
//   - FSM state enum (the MUL state exists only when EXEC_MUL_EN is defined)
//   - mul_k_legal(): checks the multiplier step width against the datapath width
// Configuration macro: EXEC_MUL_EN (enables the iterative multiplier).
package exec_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_MUL  = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef EXEC_MUL_EN
    ST_MUL  = 2'd1,
`endif
    ST_HOLD = 2'd2
  } exec_state_t;

  // Step width must be 1, 2 or 4 and must divide the datapath width.
  function automatic bit mul_k_legal(input int n, input int k);
    return ((k == 1) || (k == 2) || (k == 4)) && (n >= k) && ((n % k) == 0);
  endfunction

endpackage

// File: rtl/exec_mul_iter.sv
// exec_mul_iter: iterative shift-add multiplier, MUL_K multiplier bits per cycle.
// Produces the low N bits of the unsigned product after N/MUL_K step cycles.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   start         load operands (one-cycle pulse); steps begin next cycle
//   multiplicand  operand a, multiplier  operand b
//   done          high during the cycle of the final step
//   product       accumulator including the current step; final value when done=1
// Used only when EXEC_MUL_EN is defined.
module exec_mul_iter
  import exec_pkg::*;
#(
  parameter int N     = 64,
  parameter int MUL_K = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] multiplicand,
  input  logic [N-1:0] multiplier,
  output logic         done,
  output logic [N-1:0] product
);

  localparam int STEPS = N / MUL_K;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  if (!mul_k_legal(N, MUL_K)) begin : g_bad_cfg
    $error("exec_mul_iter: MUL_K must be 1, 2 or 4 and divide N");
  end

  logic             running_q, running_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     mcand_q, mcand_d;
  logic [N-1:0]     mplier_q, mplier_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [N-1:0]     partial;

  always_comb begin
    // Partial product for the low MUL_K multiplier bits, modulo 2^N.
    partial = '0;
    for (int i = 0; i < MUL_K; i++) begin
      if (mplier_q[i]) partial = partial + (mcand_q << i);
    end
    product = acc_q + partial;
    done    = running_q && (cnt_q == LAST);

    running_d = running_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;

    if (start) begin
      running_d = 1'b1;
      cnt_d     = '0;
      mcand_d   = multiplicand;
      mplier_d  = multiplier;
      acc_d     = '0;
    end else if (running_q) begin
      acc_d    = product;
      mcand_d  = mcand_q << MUL_K;
      mplier_d = mplier_q >> MUL_K;
      cnt_d    = cnt_q + CNT_W'(1);
      if (done) begin
        running_d = 1'b0;
        cnt_d     = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      running_q <= 1'b0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
    end else begin
      running_q <= running_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
    end
  end

endmodule

// File: rtl/execute_pipe.sv
// execute_pipe: single-entry execute stage (ALU, branch target, optional multiply).
// Handshake: an operation is taken on a rising edge where in_valid & in_ready;
// a result is delivered on a rising edge where out_valid & out_ready. Outputs are
// held stable while out_valid=1 and out_ready=0. Only one operation is held.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid / in_ready        upstream handshake
//   AluSrc, AluControl         operand-b select, operation code
//   PC_E, signImm_E, readData1_E, readData2_E   operands (width N)
//   out_valid / out_ready      downstream handshake
//   PCBranch_E, aluResult_E, writeData_E, zero_E  registered results
//   busy                       multiply in progress
// Configuration macro: EXEC_MUL_EN (iterative multiplier; without it code 1000 yields 0).
module execute_pipe
  import exec_pkg::*;
#(
  parameter int N     = 64,
  parameter int MUL_K = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         AluSrc,
  input  logic [3:0]   AluControl,
  input  logic [N-1:0] PC_E,
  input  logic [N-1:0] signImm_E,
  input  logic [N-1:0] readData1_E,
  input  logic [N-1:0] readData2_E,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] PCBranch_E,
  output logic [N-1:0] aluResult_E,
  output logic [N-1:0] writeData_E,
  output logic         zero_E,
  output logic         busy
);

  exec_state_t  state_q, state_d;
  logic [N-1:0] result_q, result_d;
  logic [N-1:0] branch_q, branch_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic         zero_q, zero_d;
  logic [N-1:0] opb;
  logic [N-1:0] alu_out;
  logic         accept;

  function automatic logic [N-1:0] alu_op(input logic [3:0] ctrl,
                                          input logic [N-1:0] a,
                                          input logic [N-1:0] b);
    logic [N-1:0] r;
    case (ctrl)
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_PASS: r = b;
      ALU_NOR:  r = ~(a | b);
      default:  r = '0;  // includes MUL, which is handled by the multiplier
    endcase
    return r;
  endfunction

  assign opb      = AluSrc ? signImm_E : readData2_E;
  assign alu_out  = alu_op(AluControl, readData1_E, opb);
  assign in_ready = (state_q == ST_IDLE) && !reset;
  assign accept   = in_valid && in_ready;
  assign out_valid = (state_q == ST_HOLD) && !reset;

`ifdef EXEC_MUL_EN
  logic         mul_start;
  logic         mul_done;
  logic [N-1:0] mul_product;

  exec_mul_iter #(.N(N), .MUL_K(MUL_K)) u_mul (
    .clk          (clk),
    .reset        (reset),
    .start        (mul_start),
    .multiplicand (readData1_E),
    .multiplier   (opb),
    .done         (mul_done),
    .product      (mul_product)
  );

  assign busy = (state_q == ST_MUL) && !reset;
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    branch_d = branch_q;
    wdata_d  = wdata_q;
    zero_d   = zero_q;
`ifdef EXEC_MUL_EN
    mul_start = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          branch_d = PC_E + (signImm_E << 2);
          wdata_d  = readData2_E;
`ifdef EXEC_MUL_EN
          if (AluControl == ALU_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else
`endif
          begin
            result_d = alu_out;
            zero_d   = (alu_out == '0);
            state_d  = ST_HOLD;
          end
        end
      end
`ifdef EXEC_MUL_EN
      ST_MUL: begin
        // Final step's sum is taken straight from the multiplier's adder.
        if (mul_done) begin
          result_d = mul_product;
          zero_d   = (mul_product == '0);
          state_d  = ST_HOLD;
        end
      end
`endif
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      branch_q <= '0;
      wdata_q  <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      branch_q <= branch_d;
      wdata_q  <= wdata_d;
      zero_q   <= zero_d;
    end
  end

  assign aluResult_E = result_q;
  assign PCBranch_E  = branch_q;
  assign writeData_E = wdata_q;
  assign zero_E      = zero_q;

endmodule

// File: tb/tb_execute_pipe.sv
// tb_execute_pipe: randomized self-checking bench for execute_pipe.
// Expected results come from a plain-arithmetic model of the operation codes.
module tb_execute_pipe;

  localparam int N     = 64;
  localparam int MUL_K = 2;
`ifdef EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic         AluSrc;
  logic [3:0]   AluControl;
  logic [N-1:0] PC_E, signImm_E, readData1_E, readData2_E;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] PCBranch_E, aluResult_E, writeData_E;
  logic         zero_E;
  logic         busy;

  int chk_cnt = 0;
  int err_cnt = 0;

  execute_pipe #(.N(N), .MUL_K(MUL_K)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .AluSrc      (AluSrc),
    .AluControl  (AluControl),
    .PC_E        (PC_E),
    .signImm_E   (signImm_E),
    .readData1_E (readData1_E),
    .readData2_E (readData2_E),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .PCBranch_E  (PCBranch_E),
    .aluResult_E (aluResult_E),
    .writeData_E (writeData_E),
    .zero_E      (zero_E),
    .busy        (busy)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [N-1:0] model_res(input logic [3:0] c, input logic [N-1:0] a,
                                             input logic [N-1:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return b;
      4'b1100: return ~(a | b);
      4'b1000: return MUL_EN ? (a * b) : '0;
      default: return '0;
    endcase
  endfunction

  function automatic bit is_mul(input logic [3:0] c);
    return MUL_EN && (c == 4'b1000);
  endfunction

  // ---------------- drivers ----------------
  task automatic scramble();
    in_valid    = 1'($urandom_range(0, 1));
    AluSrc      = 1'($urandom_range(0, 1));
    AluControl  = 4'($urandom);
    PC_E        = {$urandom, $urandom};
    signImm_E   = {$urandom, $urandom};
    readData1_E = {$urandom, $urandom};
    readData2_E = {$urandom, $urandom};
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("in_ready_idle", N'(in_ready), N'(1));
  endtask

  task automatic drive_op(input logic [3:0] c, input logic src, input logic [N-1:0] pc,
                          input logic [N-1:0] imm, input logic [N-1:0] r1, input logic [N-1:0] r2);
    in_valid    = 1'b1;
    AluControl  = c;
    AluSrc      = src;
    PC_E        = pc;
    signImm_E   = imm;
    readData1_E = r1;
    readData2_E = r2;
  endtask

  // Issues one op, disturbs the inputs while it runs, stalls the output, then releases it.
  task automatic send_op(input logic [3:0] c, input logic src, input logic [N-1:0] pc,
                         input logic [N-1:0] imm, input logic [N-1:0] r1,
                         input logic [N-1:0] r2, input int stall);
    logic [N-1:0] exp_res, exp_br;
    int lat, bcnt, exp_lat;
    bit stable;
    exp_res = model_res(c, r1, src ? imm : r2);
    exp_br  = pc + (imm << 2);
    exp_lat = is_mul(c) ? (N / MUL_K + 1) : 1;
    wait_ready();
    if (!in_ready) return;
    out_ready = 1'b0;
    drive_op(c, src, pc, imm, r1, r2);
    @(negedge clk);
    lat  = 1;
    bcnt = 0;
    while (!out_valid && lat < 200) begin
      if (busy) bcnt++;
      scramble();
      @(negedge clk);
      lat++;
    end
    check_eq("latency", N'(lat), N'(exp_lat));
    check_eq("busy_cycles", N'(bcnt), N'(is_mul(c) ? N / MUL_K : 0));
    check_eq("result", aluResult_E, exp_res);
    check_eq("zero", N'(zero_E), N'(exp_res == '0));
    check_eq("pc_branch", PCBranch_E, exp_br);
    check_eq("write_data", writeData_E, r2);
    stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      scramble();
      @(negedge clk);
      if (!(out_valid && !in_ready && !busy && aluResult_E === exp_res &&
            PCBranch_E === exp_br && writeData_E === r2 && zero_E === (exp_res == '0)))
        stable = 1'b0;
    end
    check_eq("hold_stable", N'(stable), N'(1));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("valid_drop", N'(out_valid), N'(0));
    check_eq("ready_again", N'(in_ready), N'(1));
    out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] codes [9];

  initial begin
    bit saw_valid;
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000, 4'b0011, 4'b1111};
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    AluSrc = 1'b0;
    AluControl = '0;
    PC_E = '0;
    signImm_E = '0;
    readData1_E = '0;
    readData2_E = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", N'(in_ready), N'(0));
    check_eq("rst_out_valid", N'(out_valid), N'(0));
    check_eq("rst_busy", N'(busy), N'(0));
    check_eq("rst_result", aluResult_E, '0);
    check_eq("rst_branch", PCBranch_E, '0);
    check_eq("rst_wdata", writeData_E, '0);
    check_eq("rst_zero", N'(zero_E), N'(0));
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", N'(in_ready), N'(1));

    // Directed: ADD 5+7, SUB 9-9 with branch, MUL wide value, backpressure, MUL 4x4.
    send_op(4'b0010, 1'b0, 64'h0, 64'h0, 64'd5, 64'd7, 0);
    send_op(4'b0110, 1'b1, 64'h100, 64'd9, 64'd9, 64'd3, 0);
    send_op(4'b1000, 1'b0, 64'h40, 64'h1, 64'hFFFF_FFFF, 64'd3, 0);
    send_op(4'b0001, 1'b0, 64'h8, 64'hFFFF_FFFF_FFFF_FFFF, 64'hA0, 64'h0B, 5);
    send_op(4'b1000, 1'b0, 64'h0, 64'h0, 64'd4, 64'd4, 0);
    send_op(4'b1000, 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 2);

    // Reset while an operation is outstanding (mid-multiply if present, else in HOLD).
    wait_ready();
    out_ready = 1'b1;
    drive_op(4'b1000, 1'b0, 64'h0, 64'h0, 64'd123, 64'd456);
    @(negedge clk);
    in_valid = 1'b0;
    saw_valid = out_valid && MUL_EN;
    for (int i = 1; i < 10 && MUL_EN; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_valid", N'(out_valid), N'(0));
    check_eq("mid_rst_busy", N'(busy), N'(0));
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check_eq("mid_rst_no_beat", N'(saw_valid), N'(0));
    check_eq("mid_rst_ready", N'(in_ready), N'(1));
    out_ready = 1'b0;
    send_op(4'b0010, 1'b0, 64'h0, 64'h0, 64'd1, 64'd1, 0);

    // Randomized operations.
    for (int k = 0; k < 30; k++) begin
      logic [N-1:0] r1, r2;
      r1 = {$urandom, $urandom};
      r2 = ($urandom_range(0, 3) == 0) ? r1 : {$urandom, $urandom};
      send_op(codes[$urandom_range(0, 8)], 1'($urandom_range(0, 1)), {$urandom, $urandom},
              ($urandom_range(0, 3) == 0) ? r1 : {$urandom, $urandom}, r1, r2,
              $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/execute_pipe.md
EXECUTE_PIPE -- requirements
Module: execute_pipe

Interface
REQ-001 Parameter N, default 64: datapath width in bits.
REQ-002 Parameter MUL_K, default 2: multiplier bits retired per cycle; SHALL be 1, 2 or 4, and N SHALL be divisible by MUL_K.
REQ-003 Clock is clk, a single clock; reset is reset, synchronous and active-high; both SHALL be the first two ports.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  upstream operation present; in_ready  output  1  block can accept.
REQ-007 AluSrc  input  1  1 = operand b is signImm_E, 0 = readData2_E; AluControl  input  4  operation code.
REQ-008 PC_E, signImm_E, readData1_E, readData2_E  input  N each  operands.
REQ-009 out_valid  output  1  result held; out_ready  input  1  downstream accepts.
REQ-010 PCBranch_E, aluResult_E, writeData_E  output  N each; zero_E  output  1; busy  output  1  multiply in progress.

Function
REQ-011 AluControl codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 PASS-B, 1100 NOR, 1000 MUL (low N bits of the unsigned product); any other code SHALL yield result 0.
REQ-012 PCBranch_E SHALL be PC_E + (signImm_E << 2), truncated to N bits; writeData_E SHALL be readData2_E; zero_E SHALL be 1 iff the result is 0.
REQ-013 Operands and AluSrc SHALL be captured on the acceptance edge, defined as in_valid & in_ready.
REQ-014 FSM states: IDLE, MUL, HOLD. The FSM SHALL move IDLE->HOLD on acceptance of a non-MUL op, IDLE->MUL on acceptance of MUL, MUL->HOLD after the last step, and HOLD->IDLE when out_ready=1.
REQ-015 in_ready SHALL be 1 only in IDLE with reset low; the block SHALL hold at most one operation.
REQ-016 A non-MUL op SHALL produce out_valid one cycle after acceptance.
REQ-017 A MUL op SHALL take N/MUL_K step cycles, and out_valid SHALL rise N/MUL_K+1 cycles after acceptance; busy SHALL be 1 in MUL only.
REQ-018 While out_valid=1 and out_ready=0, all outputs SHALL stay stable.
REQ-019 out_valid SHALL be 1 in HOLD only; on the HOLD->IDLE edge it SHALL drop, and a new op SHALL be accepted no earlier than the next cycle.
REQ-020 Inputs SHALL be ignored while in_ready=0; a toggling in_valid SHALL NOT disturb a running multiply.
REQ-021 Multiply steps: the multiplier is shifted right by MUL_K, the multiplicand is shifted left by MUL_K, and the partial product is accumulated modulo 2^N.

Reset
REQ-022 While reset=1, the FSM SHALL be set to IDLE, the step counter to 0, and all registered outputs to 0; out_valid, busy and in_ready SHALL be 0.
REQ-023 A reset asserted mid-multiply or in HOLD SHALL discard the operation with no output beat.
REQ-024 One cycle after reset deasserts, in_ready SHALL be 1.

Configuration
REQ-025 With macro EXEC_MUL_EN defined, MUL SHALL behave per REQ-017 and REQ-021.
REQ-026 Without EXEC_MUL_EN, the MUL state and multiplier SHALL be absent; code 1000 SHALL complete in 1 cycle with result 0 and zero_E=1, and busy SHALL be tied to 0.

Structure
REQ-027 Package exec_pkg SHALL hold the AluControl code constants, the FSM state enum, and the MUL_K legality check.
REQ-028 Sub-module exec_mul_iter SHALL be the only sub-module; it SHALL be parametrised on N and MUL_K with start/done signals, and SHALL be instantiated only under EXEC_MUL_EN.

Verification
REQ-029 Test 1: ADD with a=5, b=7, AluSrc=0, out_ready=1. Required: out_valid next cycle, result 12, zero_E=0.
REQ-030 Test 2: SUB with a=9, signImm=9, AluSrc=1, PC=0x100. Required: result 0, zero_E=1, PCBranch_E=0x124.
REQ-031 Test 3: MUL 0xFFFF_FFFF x 3 with N=64, MUL_K=2. Required: result 0x2_FFFF_FFFD, out_valid 33 cycles after acceptance, busy high 32 cycles.
REQ-032 Test 4: backpressure, out_ready=0 for 5 cycles after out_valid. Required: outputs stable, in_ready=0, and the result is accepted on the cycle out_ready rises.
REQ-033 Test 5: reset asserted at MUL step 10. Required: next cycle IDLE, out_valid=0, no beat emitted; a following ADD 1+1 returns 2.
REQ-034 Test 6: without EXEC_MUL_EN, issue MUL 4x4. Required: 1-cycle latency, result 0, zero_E=1.
